// File: rtl/uart_rx_fifo_param.sv
// Oversampled UART receiver with integrated first-word-fall-through receive FIFO,
// break detection, sticky overrun and character timeout. Optional feature macro: UART_RX_MAJORITY_EN.
module uart_rx_fifo_param #(
  parameter int unsigned OVS        = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TOUT_TICKS = 640
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   srx_pad_i,
  input  logic [1:0]             cfg_bits,
  input  logic                   cfg_pe,
  input  logic                   cfg_ep,
  input  logic                   cfg_sp,
  input  logic                   rf_pop,
  input  logic                   ovr_clr,
  output logic [10:0]            rf_data_out,
  output logic [$clog2(DEPTH):0] rf_count,
  output logic                   rf_empty,
  output logic                   rf_error_bit,
  output logic                   rf_overrun,
  output logic                   rx_timeout
);
  localparam int unsigned TW = $clog2(OVS);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(TOUT_TICKS + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT} state_e;

  logic          sync1_q, sync2_q;
  state_e        state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d, errcnt_q, errcnt_d;
  logic [10:0]   head_q, head_d;
  logic          empty_q, empty_d, errbit_q, errbit_d, ovr_q, ovr_d, tout_q, tout_d;
  logic [IW-1:0] icnt_q, icnt_d;

  logic        rx, cnt_st, samp_evt, samp_bit, push, do_push, do_pop;
  logic        brk, perr, ferr, xpar, head_err;
  logic [2:0]  last_idx;
  logic [10:0] wword;

  assign rx       = sync2_q;
  assign cnt_st   = (state_q == S_START) || (state_q == S_DATA) ||
                    (state_q == S_PARITY) || (state_q == S_STOP);
  assign last_idx = 3'(cfg_bits) + 3'd4;

`ifdef UART_RX_MAJORITY_EN
  // 2-of-3 vote over tcnt==1, tcnt==0 and the tick after; decision lands one tick late
  logic s1_q, s1_d, s0_q, s0_d, pend_q, pend_d;
  assign samp_evt = enable && cnt_st && pend_q;
  assign samp_bit = (s1_q & s0_q) | (s1_q & rx) | (s0_q & rx);
  always_comb begin
    s1_d   = s1_q;
    s0_d   = s0_q;
    pend_d = pend_q;
    if (enable) begin
      pend_d = cnt_st && (tcnt_q == '0);
      if (tcnt_q == TW'(1)) s1_d = rx;
      if (tcnt_q == '0)     s0_d = rx;
    end
  end
`else
  assign samp_evt = enable && cnt_st && (tcnt_q == '0);
  assign samp_bit = rx;
`endif

  assign xpar  = (^data_q) ^ par_q;
  assign perr  = cfg_pe && (cfg_sp ? (par_q == cfg_ep) : (xpar == cfg_ep));
  assign ferr  = ~samp_bit;
  assign brk   = (data_q == 8'd0) && (!cfg_pe || !par_q) && !samp_bit;
  assign wword = {data_q, brk, perr, ferr};

  // Receiver FSM; tick counter free-runs with period OVS once a frame has started
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    data_d  = data_q;
    par_d   = par_q;
    push    = 1'b0;
    if (enable && cnt_st) tcnt_d = (tcnt_q == '0) ? TW'(OVS - 1) : tcnt_q - TW'(1);
    case (state_q)
      S_IDLE: if (enable && !rx) begin
        state_d = S_START;
        tcnt_d  = TW'(OVS / 2 - 1);
      end
      S_START: if (samp_evt) begin
        if (samp_bit) state_d = S_IDLE;
        else begin
          state_d = S_DATA;
          bidx_d  = 3'd0;
          data_d  = 8'd0;
        end
      end
      S_DATA: if (samp_evt) begin
        data_d[bidx_q] = samp_bit;
        if (bidx_q == last_idx) state_d = cfg_pe ? S_PARITY : S_STOP;
        else                    bidx_d  = bidx_q + 3'd1;
      end
      S_PARITY: if (samp_evt) begin
        par_d   = samp_bit;
        state_d = S_STOP;
      end
      S_STOP: if (samp_evt) begin
        push    = 1'b1;
        state_d = brk ? S_BRK_WAIT : S_IDLE;
      end
      S_BRK_WAIT: if (enable && rx) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping; a pop on an empty FIFO is honoured only alongside a push
  always_comb begin
    do_pop   = rf_pop && ((count_q != '0) || push);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wptr_d   = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = do_pop  ? rptr_q + AW'(1) : rptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    empty_d  = (count_d == '0);
    ovr_d    = (push && !do_push) ? 1'b1 : (ovr_clr ? 1'b0 : ovr_q);
    head_err = (count_q != '0) ? (|head_q[2:0]) : (|wword[2:0]);
    errcnt_d = errcnt_q + CW'(do_push && (|wword[2:0])) - CW'(do_pop && head_err);
    errbit_d = (errcnt_d != '0);
    if (count_d == '0)                        head_d = 11'd0;
    else if (do_push && (rptr_d == wptr_q))   head_d = wword;
    else                                      head_d = mem_q[rptr_d];
    icnt_d = icnt_q;
    if (push || do_pop || (count_q == '0))                                    icnt_d = '0;
    else if (enable && (state_q == S_IDLE) && (icnt_q != IW'(TOUT_TICKS)))    icnt_d = icnt_q + IW'(1);
    tout_d = (icnt_d == IW'(TOUT_TICKS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      state_q  <= S_IDLE;
      tcnt_q   <= '0;
      bidx_q   <= 3'd0;
      data_q   <= 8'd0;
      par_q    <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      errcnt_q <= '0;
      head_q   <= 11'd0;
      empty_q  <= 1'b1;
      errbit_q <= 1'b0;
      ovr_q    <= 1'b0;
      icnt_q   <= '0;
      tout_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
      s1_q     <= 1'b1;
      s0_q     <= 1'b1;
      pend_q   <= 1'b0;
`endif
    end else begin
      sync1_q  <= srx_pad_i;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      bidx_q   <= bidx_d;
      data_q   <= data_d;
      par_q    <= par_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      errcnt_q <= errcnt_d;
      head_q   <= head_d;
      empty_q  <= empty_d;
      errbit_q <= errbit_d;
      ovr_q    <= ovr_d;
      icnt_q   <= icnt_d;
      tout_q   <= tout_d;
`ifdef UART_RX_MAJORITY_EN
      s1_q     <= s1_d;
      s0_q     <= s0_d;
      pend_q   <= pend_d;
`endif
    end
  end

  // Storage array is not reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wword;
  end

  assign rf_data_out  = head_q;
  assign rf_count     = count_q;
  assign rf_empty     = empty_q;
  assign rf_error_bit = errbit_q;
  assign rf_overrun   = ovr_q;
  assign rx_timeout   = tout_q;
endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: serial frames driven on the pad, results checked
// against a queue model of the receive FIFO and a frame-decoding function.
module tb_uart_rx_fifo_param;
  localparam int unsigned OVS   = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned TOUT  = 640;

  logic        clk, rst, enable, srx_pad_i;
  logic [1:0]  cfg_bits;
  logic        cfg_pe, cfg_ep, cfg_sp, rf_pop, ovr_clr;
  logic [10:0] rf_data_out;
  logic [4:0]  rf_count;
  logic        rf_empty, rf_error_bit, rf_overrun, rx_timeout;

  int          total = 0;
  int          bad   = 0;
  logic [10:0] mq[$];
  logic        m_ovr;
  logic [7:0]  bytes [18];

  uart_rx_fifo_param #(.OVS(OVS), .DEPTH(DEPTH), .TOUT_TICKS(TOUT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .srx_pad_i(srx_pad_i),
    .cfg_bits(cfg_bits), .cfg_pe(cfg_pe), .cfg_ep(cfg_ep), .cfg_sp(cfg_sp),
    .rf_pop(rf_pop), .ovr_clr(ovr_clr), .rf_data_out(rf_data_out),
    .rf_count(rf_count), .rf_empty(rf_empty), .rf_error_bit(rf_error_bit),
    .rf_overrun(rf_overrun), .rx_timeout(rx_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] exp_word(input logic [7:0] d, input logic [1:0] bits,
      input logic pe, input logic ep, input logic sp, input logic par, input logic stop);
    int         n;
    logic [7:0] dm;
    logic       x, pr, bk;
    n  = int'(bits) + 5;
    dm = d & 8'((1 << n) - 1);
    x  = (^dm) ^ par;
    pr = 1'b0;
    if (pe) begin
      case ({ep, sp})
        2'b00:   pr = (x == 1'b0);
        2'b10:   pr = (x == 1'b1);
        2'b01:   pr = (par != 1'b1);
        default: pr = (par != 1'b0);
      endcase
    end
    bk = (dm == 8'd0) && (!pe || !par) && !stop;
    return {dm, bk, pr, !stop};
  endfunction

  function automatic logic model_err();
    foreach (mq[i]) if (mq[i][2:0] != 3'b000) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_state(input string tag);
    check({tag, ".count"}, 32'(rf_count), 32'(mq.size()));
    check({tag, ".empty"}, 32'(rf_empty), 32'(mq.size() == 0));
    check({tag, ".head"},  32'(rf_data_out), (mq.size() == 0) ? 32'd0 : 32'(mq[0]));
    check({tag, ".err"},   32'(rf_error_bit), 32'(model_err()));
    check({tag, ".ovr"},   32'(rf_overrun), 32'(m_ovr));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) enable = 1'b1;
      @(negedge clk) enable = 1'b0;
      @(negedge clk);
    end
  endtask

  // One bit period; optionally pulses rf_pop alongside enable tick number pop_at
  task automatic send_bit(input logic b, input int pop_at);
    srx_pad_i = b;
    for (int m = 0; m < int'(OVS); m++) begin
      @(negedge clk) begin enable = 1'b1; rf_pop = (m == pop_at); end
      @(negedge clk) begin enable = 1'b0; rf_pop = 1'b0; end
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int pop_at);
    send_bit(1'b0, -1);
    for (int i = 0; i < int'(cfg_bits) + 5; i++) send_bit(d[i], -1);
    if (cfg_pe) send_bit(par, -1);
    send_bit(stop, pop_at);
    srx_pad_i = 1'b1;
  endtask

  task automatic model_push(input logic [10:0] w);
    if (mq.size() < DEPTH) mq.push_back(w);
    else m_ovr = 1'b1;
  endtask

  task automatic pop();
    @(negedge clk) rf_pop = 1'b1;
    @(negedge clk) rf_pop = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic set_cfg(input logic [1:0] b, input logic pe, input logic ep, input logic sp);
    cfg_bits = b; cfg_pe = pe; cfg_ep = ep; cfg_sp = sp;
  endtask

  initial begin
    logic [7:0]  d;
    logic [1:0]  b;
    logic        pe, ep, sp, par, stop;

    rst = 1'b1; enable = 1'b0; srx_pad_i = 1'b1; rf_pop = 1'b0; ovr_clr = 1'b0;
    m_ovr = 1'b0;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check_state("reset");
    check("reset.tout", 32'(rx_timeout), 32'd0);

    // 8N1 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    model_push(exp_word(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    check("a5.word", 32'(rf_data_out), 32'h528);
    check_state("a5");
    pop();
    check_state("a5_pop");

    // 7E1 with bad and good parity
    set_cfg(2'b10, 1'b1, 1'b1, 1'b0);
    send_frame(8'h41, 1'b1, 1'b1, -1);
    model_push(exp_word(8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1));
    check("7e1_p1.word", 32'(rf_data_out), 32'h20A);
    pop();
    send_frame(8'h41, 1'b0, 1'b1, -1);
    model_push(exp_word(8'h41, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
    check("7e1_p0.word", 32'(rf_data_out), 32'h208);
    check_state("7e1");
    pop();

    // Randomized frame formats
    for (int k = 0; k < 10; k++) begin
      d    = 8'($urandom);
      b    = 2'($urandom_range(0, 3));
      pe   = 1'($urandom_range(0, 1));
      ep   = 1'($urandom_range(0, 1));
      sp   = 1'($urandom_range(0, 1));
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      set_cfg(b, pe, ep, sp);
      send_frame(d, par, stop, -1);
      ticks(2 * OVS);
      model_push(exp_word(d, b, pe, ep, sp, par, stop));
      check_state($sformatf("rand%0d", k));
      pop();
      check("rand.pop_empty", 32'(rf_empty), 32'd1);
    end

    // Short low glitch on an idle line
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    srx_pad_i = 1'b0;
    ticks(OVS / 4);
    srx_pad_i = 1'b1;
    ticks(2 * OVS);
    check_state("glitch");
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    model_push(exp_word(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    check_state("glitch_after");
    pop();

    // Break: line low for two frames
    srx_pad_i = 1'b0;
    ticks(2 * 10 * OVS);
    srx_pad_i = 1'b1;
    ticks(2 * OVS);
    model_push(exp_word(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    check("brk.word", 32'(rf_data_out), 32'h005);
    check_state("brk");
    send_frame(8'h5A, 1'b0, 1'b1, -1);
    model_push(exp_word(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    check_state("brk_next");
    pop();
    check_state("brk_pop");
    pop();

    // Character timeout
    d = 8'($urandom);
    send_frame(d, 1'b0, 1'b1, -1);
    model_push(exp_word(d, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    ticks(600);
    check("tout.early", 32'(rx_timeout), 32'd0);
    ticks(60);
    check("tout.set", 32'(rx_timeout), 32'd1);
    pop();
    check("tout.clr", 32'(rx_timeout), 32'd0);
    check_state("tout");

    // Overrun on a full FIFO
    for (int i = 0; i < 17; i++) begin
      bytes[i] = 8'($urandom);
      send_frame(bytes[i], 1'b0, 1'b1, -1);
      model_push(exp_word(bytes[i], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    check_state("full");
    check("full.head_byte1", 32'(rf_data_out[10:3]), 32'(bytes[0]));
    @(negedge clk) ovr_clr = 1'b1;
    @(negedge clk) ovr_clr = 1'b0;
    m_ovr = 1'b0;
    check_state("ovr_clr");

    // Pop coincident with the stop-bit push while full
    bytes[17] = 8'($urandom);
    send_frame(bytes[17], 1'b0, 1'b1, OVS / 2 + 1);
    void'(mq.pop_front());
    mq.push_back(exp_word(bytes[17], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    check_state("push_pop_full");
    check("push_pop.head_byte2", 32'(rf_data_out[10:3]), 32'(bytes[1]));
    for (int i = 0; i < int'(DEPTH); i++) begin
      pop();
      check_state($sformatf("drain%0d", i));
    end

    // Reset in the middle of a frame
    send_frame(8'h96, 1'b0, 1'b1, -1);
    srx_pad_i = 1'b0;
    ticks(3 * OVS);
    @(negedge clk) begin rst = 1'b1; srx_pad_i = 1'b1; end
    @(negedge clk) rst = 1'b0;
    mq.delete();
    m_ovr = 1'b0;
    ticks(2 * OVS);
    check_state("midrst");
    check("midrst.tout", 32'(rx_timeout), 32'd0);
    send_frame(8'hC3, 1'b0, 1'b1, -1);
    model_push(exp_word(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    check_state("midrst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
